// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the MIPS hazard/pipeline-control sequencer.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    WAIT  = 2'd2
  } hazard_state_t;

  localparam int LB_STALL_DEF = 2;
  localparam int CNT_STATE_W  = 2;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard sequencer (slave).
interface hazard_ctrl_if #(
  parameter int REG_BITS  = 5,
  parameter int CNT_WIDTH = 16
);
  logic [REG_BITS-1:0]  rs_D, rt_D, writereg_E, writereg_M;
  logic                 RegWrite_E, MemtoReg_E, MemtoReg_M;
  logic                 branch_D, jump_D, jregister_D, branch_taken_D;
  logic                 dmem_ready;
  logic                 bubble_sel;
  logic                 stall_F, stall_D, stall_E, stall_M;
  logic                 flush_D, flush_E;
  logic [CNT_WIDTH-1:0] stall_cycles, flush_count;

  modport master (
    output rs_D, rt_D, writereg_E, writereg_M, RegWrite_E, MemtoReg_E, MemtoReg_M,
           branch_D, jump_D, jregister_D, branch_taken_D, dmem_ready,
    input  bubble_sel, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
           stall_cycles, flush_count
  );

  modport slave (
    input  rs_D, rt_D, writereg_E, writereg_M, RegWrite_E, MemtoReg_E, MemtoReg_M,
           branch_D, jump_D, jregister_D, branch_taken_D, dmem_ready,
    output bubble_sel, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_cmp.sv
// Combinational ID-stage register compare: load-use / branch-operand hazards and stall length.
module hazard_cmp #(
  parameter int REG_BITS = 5,
  parameter int LB_STALL = 2
) (
  input  logic [REG_BITS-1:0] rs_D,
  input  logic [REG_BITS-1:0] rt_D,
  input  logic [REG_BITS-1:0] writereg_E,
  input  logic [REG_BITS-1:0] writereg_M,
  input  logic                RegWrite_E,
  input  logic                MemtoReg_E,
  input  logic                MemtoReg_M,
  input  logic                branch_D,
  input  logic                jregister_D,
  output logic                lw_hz,
  output logic                br_hz,
  output logic [2:0]          stall_len
);

  logic rs_e, rt_e, rs_m, rt_m;
  logic match_e, match_m, ctl_flow;

  // $0 is hardwired, so it can never be a real producer/consumer pair.
  assign rs_e = (rs_D != '0) && (rs_D == writereg_E);
  assign rt_e = (rt_D != '0) && (rt_D == writereg_E);
  assign rs_m = (rs_D != '0) && (rs_D == writereg_M);
  assign rt_m = (rt_D != '0) && (rt_D == writereg_M);

  // jr reads only rs; branches read both operands.
  assign match_e  = rs_e | (branch_D & rt_e);
  assign match_m  = rs_m | (branch_D & rt_m);
  assign ctl_flow = branch_D | jregister_D;

  assign lw_hz = MemtoReg_E & (rs_e | rt_e);
  assign br_hz = ctl_flow & ((RegWrite_E & match_e) | (MemtoReg_M & match_m));

  assign stall_len = (ctl_flow && MemtoReg_E && match_e) ? 3'(LB_STALL) : 3'd1;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall/flush sequencer for the five-stage pipeline with saturating event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_BITS  = 5,
  parameter int CNT_WIDTH = 16,
  parameter int LB_STALL  = LB_STALL_DEF
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  hazard_state_t          state, state_n;
  logic [CNT_STATE_W-1:0] cnt, cnt_n;
  logic [CNT_WIDTH-1:0]   stall_cnt, flush_cnt;
  logic                   lw_hz, br_hz, hazard, redirect;
  logic [2:0]             stall_len;
  logic                   bubble, st_f, st_d, st_e, st_m, fl_d, fl_e;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  hazard_cmp #(.REG_BITS(REG_BITS), .LB_STALL(LB_STALL)) u_cmp (
    .rs_D        (hz.rs_D),
    .rt_D        (hz.rt_D),
    .writereg_E  (hz.writereg_E),
    .writereg_M  (hz.writereg_M),
    .RegWrite_E  (hz.RegWrite_E),
    .MemtoReg_E  (hz.MemtoReg_E),
    .MemtoReg_M  (hz.MemtoReg_M),
    .branch_D    (hz.branch_D),
    .jregister_D (hz.jregister_D),
    .lw_hz       (lw_hz),
    .br_hz       (br_hz),
    .stall_len   (stall_len)
  );

  assign hazard   = lw_hz | br_hz;
  assign redirect = hz.branch_taken_D | hz.jump_D | hz.jregister_D;

  // WAIT with memory ready behaves exactly like RUN in the same cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bubble  = 1'b0;
    st_f    = 1'b0;
    st_d    = 1'b0;
    st_e    = 1'b0;
    st_m    = 1'b0;
    fl_d    = 1'b0;
    fl_e    = 1'b0;
    if (!reset) begin
      case (state)
        RUN, WAIT: begin
          if (!hz.dmem_ready) begin
            {st_f, st_d, st_e, st_m} = 4'b1111;
            state_n = WAIT;
          end else begin
            state_n = RUN;
            if (hazard) begin
              {bubble, st_f, st_d, fl_e} = 4'b1111;
              if (stall_len > 3'd1) begin
                cnt_n   = CNT_STATE_W'(stall_len - 3'd1);
                state_n = STALL;
              end
            end else if (redirect) begin
              fl_d = 1'b1;
            end
          end
        end
        STALL: begin
          if (!hz.dmem_ready) begin
            {st_f, st_d, st_e, st_m} = 4'b1111;
          end else begin
            {bubble, st_f, st_d, fl_e} = 4'b1111;
            cnt_n = cnt - 1'b1;
            if (cnt == CNT_STATE_W'(1)) state_n = RUN;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (st_f) stall_cnt <= sat_inc(stall_cnt);
      if (fl_d) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign hz.bubble_sel   = bubble;
  assign hz.stall_F      = st_f;
  assign hz.stall_D      = st_d;
  assign hz.stall_E      = st_e;
  assign hz.stall_M      = st_m;
  assign hz.flush_D      = fl_d;
  assign hz.flush_E      = fl_e;
  assign hz.stall_cycles = reset ? '0 : stall_cnt;
  assign hz.flush_count  = reset ? '0 : flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors, negedge monitor compares.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_BITS(5), .CNT_WIDTH(16)) hif ();

  hazard_ctrl #(.REG_BITS(5), .CNT_WIDTH(16), .LB_STALL(2)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif.slave)
  );

  // {bubble_sel, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] HZ   = 7'b1110001;
  localparam logic [6:0] FRZ  = 7'b0111100;
  localparam logic [6:0] FD   = 7'b0000010;

  typedef struct {
    string       name;
    logic [6:0]  outs;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] got;
      e   = q.pop_front();
      got = {hif.bubble_sel, hif.stall_F, hif.stall_D, hif.stall_E, hif.stall_M,
             hif.flush_D, hif.flush_E};
      checks++;
      if (got !== e.outs || hif.stall_cycles !== e.sc || hif.flush_count !== e.fc) begin
        failures++;
        $display("FAIL %s: outs got=%b want=%b stall_cycles got=%h want=%h flush_count got=%h want=%h",
                 e.name, got, e.outs, hif.stall_cycles, e.sc, hif.flush_count, e.fc);
      end
    end
  end

  task automatic step(input string name, input logic rst, input logic rdy,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] we, input logic [4:0] wm,
                      input logic rwe, input logic m2e, input logic m2m,
                      input logic br, input logic j, input logic jr, input logic bt,
                      input logic [6:0] eo, input logic [15:0] esc, input logic [15:0] efc,
                      input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    reset              = rst;
    hif.dmem_ready     = rdy;
    hif.rs_D           = rs;
    hif.rt_D           = rt;
    hif.writereg_E     = we;
    hif.writereg_M     = wm;
    hif.RegWrite_E     = rwe;
    hif.MemtoReg_E     = m2e;
    hif.MemtoReg_M     = m2m;
    hif.branch_D       = br;
    hif.jump_D         = j;
    hif.jregister_D    = jr;
    hif.branch_taken_D = bt;
    if (chk) begin
      e.name = name;
      e.outs = eo;
      e.sc   = esc;
      e.fc   = efc;
      q.push_back(e);
    end
  endtask

  task automatic idle(input string name, input logic [15:0] esc, input logic [15:0] efc);
    step(name, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, esc, efc, 1);
  endtask

  initial begin
    reset              = 1'b1;
    hif.dmem_ready     = 1'b1;
    hif.rs_D           = '0;
    hif.rt_D           = '0;
    hif.writereg_E     = '0;
    hif.writereg_M     = '0;
    hif.RegWrite_E     = 1'b0;
    hif.MemtoReg_E     = 1'b0;
    hif.MemtoReg_M     = 1'b0;
    hif.branch_D       = 1'b0;
    hif.jump_D         = 1'b0;
    hif.jregister_D    = 1'b0;
    hif.branch_taken_D = 1'b0;

    //   name            rst rdy rs rt we wm rwe m2e m2m br j jr bt  exp   sc  fc
    step("reset0",        1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 0, 1);
    step("reset1",        1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 0, 1);
    // load-use: lw $2 in EX, ID reads $2
    step("lwuse",         0, 1, 2, 0, 2, 0, 1, 1, 0, 0, 0, 0, 0, HZ,   0, 0, 1);
    idle("lwuse_after",   1, 0);
    step("reg0_nomatch",  0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, NONE, 1, 0, 1);
    // lw $3 in EX, beq $3,$4 -> two stall cycles
    step("lb_stall1",     0, 1, 3, 4, 3, 0, 1, 1, 0, 1, 0, 0, 0, HZ,   1, 0, 1);
    step("lb_stall2",     0, 1, 3, 4, 0, 3, 0, 0, 1, 1, 0, 0, 0, HZ,   2, 0, 1);
    step("lb_back_run",   0, 1, 3, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, NONE, 3, 0, 1);
    // add $5 in EX, jr $5 -> 1 stall then flush
    step("jr_alu_stall",  0, 1, 5, 0, 5, 0, 1, 0, 0, 0, 0, 1, 0, HZ,   3, 0, 1);
    step("jr_flush",      0, 1, 5, 0, 0, 5, 0, 0, 0, 0, 0, 1, 0, FD,   4, 0, 1);
    idle("jr_after",      4, 1);
    step("jr_rt_ignored", 0, 1, 6, 7, 7, 0, 1, 0, 0, 0, 0, 1, 0, FD,   4, 1, 1);
    idle("jr2_after",     4, 2);
    // branch operand from load in MEM costs one
    step("br_ld_mem",     0, 1, 8, 9, 0, 9, 0, 0, 1, 1, 0, 0, 0, HZ,   4, 2, 1);
    step("br_taken",      0, 1, 8, 9, 0, 0, 0, 0, 0, 1, 0, 0, 1, FD,   5, 2, 1);
    idle("br_after",      5, 3);
    // memory freeze in the middle of a STALL with cnt=1
    step("frz_enter",     0, 1, 3, 4, 3, 0, 1, 1, 0, 1, 0, 0, 0, HZ,   5, 3, 1);
    step("frz1",          0, 0, 3, 4, 0, 3, 0, 0, 1, 1, 0, 0, 0, FRZ,  6, 3, 1);
    step("frz2",          0, 0, 3, 4, 0, 3, 0, 0, 1, 1, 0, 0, 0, FRZ,  7, 3, 1);
    step("frz3",          0, 0, 3, 4, 0, 3, 0, 0, 1, 1, 0, 0, 0, FRZ,  8, 3, 1);
    step("frz_resume",    0, 1, 3, 4, 0, 3, 0, 0, 1, 1, 0, 0, 0, HZ,   9, 3, 1);
    idle("frz_after",     10, 3);
    // WAIT from RUN, then redirect evaluated in the cycle memory returns
    step("wait1",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 10, 3, 1);
    step("wait2",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 11, 3, 1);
    step("wait_jump",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FD,  12, 3, 1);
    idle("wait_after",    12, 4);
    // priorities: hazard over redirect, memory wait over hazard
    step("hz_over_jump",  0, 1, 2, 0, 2, 0, 1, 1, 0, 0, 1, 0, 0, HZ,  12, 4, 1);
    idle("prio_after",    13, 4);
    step("mem_over_hz",   0, 0, 2, 0, 2, 0, 1, 1, 0, 0, 0, 0, 0, FRZ, 13, 4, 1);
    step("wait_hz",       0, 1, 2, 0, 2, 0, 1, 1, 0, 0, 0, 0, 0, HZ,  14, 4, 1);
    idle("wait_hz_after", 15, 4);
    // reset in the second cycle of an LB_STALL stall
    step("rst_stall1",    0, 1, 3, 4, 3, 0, 1, 1, 0, 1, 0, 0, 0, HZ,  15, 4, 1);
    step("rst_mid",       1, 1, 3, 4, 0, 3, 0, 0, 1, 1, 0, 0, 0, NONE, 0, 0, 1);
    step("rst_is_run",    0, 1, 3, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, NONE, 0, 0, 1);
    // saturate stall_cycles with a long run of load-use hazards
    for (int i = 0; i < 65536; i++)
      step("sat_fill",    0, 1, 2, 0, 2, 0, 1, 1, 0, 0, 0, 0, 0, HZ,   0, 0, 0);
    step("sat_hold",      0, 1, 2, 0, 2, 0, 1, 1, 0, 0, 0, 0, 0, HZ, 16'hFFFF, 0, 1);
    idle("sat_stick",     16'hFFFF, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending expectations got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
